// File: rtl/flag_register.sv
// flag_register
//   Architectural status-flag register with a condition-code evaluator and a
//   small LIFO for saving/restoring flag words around interrupts and calls.
//
//   Flag layout everywhere: [0]=Z, [1]=S, [2]=C, [3]=V.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   flags_in     incoming flags from the ALU
//   flags_we     write strobe for flags_in
//   flags_mask   per-bit write enable used with flags_we
//   cond_valid   condition evaluation request (one result per request)
//   cond_code    4-bit condition code to evaluate
//   push         save the current flag register onto the stack
//   pop          restore the flag register from the stack top
//   err_clr      clears stack_err (a same-cycle new error wins)
//   flags_out    current flag register
//   taken        result of the most recent evaluation (held)
//   taken_valid  one-cycle pulse the cycle after a cond_valid request
//   stack_count  number of saved entries
//   stack_full   stack_count == DEPTH
//   stack_empty  stack_count == 0
//   stack_err    sticky misuse indicator (push+pop, push full, pop empty)
//
// Handshake: cond_valid is a fire-and-forget request with no back-pressure;
// every request sampled on a rising edge produces exactly one taken_valid
// pulse on the following cycle, with taken carrying the result. Requests may
// be issued every cycle.
module flag_register #(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     flags_in,
  input  logic                           flags_we,
  input  logic [3:0]                     flags_mask,
  input  logic                           cond_valid,
  input  logic [3:0]                     cond_code,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           err_clr,
  output logic [3:0]                     flags_out,
  output logic                           taken,
  output logic                           taken_valid,
  output logic [$clog2(DEPTH+1)-1:0]     stack_count,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           stack_err
);

  localparam int CW = $clog2(DEPTH+1);

  logic [3:0]    flags_q;
  logic          taken_q;
  logic          taken_valid_q;
  logic [CW-1:0] count_q;
  logic          err_q;
  logic [3:0]    stack_mem [DEPTH];

  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          err_set;
  logic [3:0]    stack_top;
  logic [3:0]    nf;
  logic          cond_result;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A simultaneous push and pop is treated as misuse: neither happens.
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign err_set = (push && pop) || (push && !pop && full) || (pop && !push && empty);

  // Read mux for entry count-1; written as a compare loop so the index
  // width never has to match the array size.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) stack_top = stack_mem[i];
    end
  end

  // Next flag value: a valid pop overrides any same-cycle write.
  always_comb begin
    nf = flags_q;
    if (pop_ok) begin
      nf = stack_top;
    end else if (flags_we) begin
      nf = (flags_in & flags_mask) | (flags_q & ~flags_mask);
    end
  end

  // Conditions are evaluated on nf so a same-cycle write or pop is forwarded.
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic z, s, c, v;
    logic r;
    z = f[0];
    s = f[1];
    c = f[2];
    v = f[3];
    case (code)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = s;
      4'd5:    r = !s;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = c && !z;
      4'd9:    r = !c || z;
      4'd10:   r = (s == v);
      4'd11:   r = (s != v);
      4'd12:   r = !z && (s == v);
      4'd13:   r = z || (s != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_result = eval_cond(cond_code, nf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q       <= '0;
      taken_q       <= 1'b0;
      taken_valid_q <= 1'b0;
      count_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      flags_q       <= nf;
      taken_valid_q <= cond_valid;
      if (cond_valid) taken_q <= cond_result;
      if (push_ok) begin
        count_q <= count_q + CW'(1);
      end else if (pop_ok) begin
        count_q <= count_q - CW'(1);
      end
      // Set takes priority over clear.
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // Stack storage has no reset; entries above stack_count are unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (count_q == CW'(i))) stack_mem[i] <= flags_q;
    end
  end

  assign flags_out   = flags_q;
  assign taken       = taken_q;
  assign taken_valid = taken_valid_q;
  assign stack_count = count_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_register.sv
module tb_flag_register;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst;
  logic [3:0]    flags_in;
  logic          flags_we;
  logic [3:0]    flags_mask;
  logic          cond_valid;
  logic [3:0]    cond_code;
  logic          push;
  logic          pop;
  logic          err_clr;
  logic [3:0]    flags_out;
  logic          taken;
  logic          taken_valid;
  logic [CW-1:0] stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  flag_register #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .flags_in(flags_in), .flags_we(flags_we), .flags_mask(flags_mask),
    .cond_valid(cond_valid), .cond_code(cond_code),
    .push(push), .pop(pop), .err_clr(err_clr),
    .flags_out(flags_out), .taken(taken), .taken_valid(taken_valid),
    .stack_count(stack_count), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [3:0]    flags;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          err;
    logic          tv;
  } st_t;

  logic [0:0] exp_q[$];
  st_t        state_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
    bit z, s, c, v;
    z = f[0]; s = f[1]; c = f[2]; v = f[3];
    case (int'(code))
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return s;
      5:  return !s;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return s == v;
      11: return s != v;
      12: return !z && (s == v);
      13: return z || (s != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'h0;
    m_stack.delete();
    m_err   = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs at the falling edge and records what the
  // DUT must show after the next rising edge.
  task automatic step(input logic [3:0] fi, input logic [3:0] mask, input logic we,
                      input logic cv, input logic [3:0] cc,
                      input logic pu, input logic po, input logic clr);
    logic [3:0] nf;
    logic       err_new;
    st_t        es;
    @(negedge clk);
    flags_in = fi; flags_mask = mask; flags_we = we;
    cond_valid = cv; cond_code = cc; push = pu; pop = po; err_clr = clr;

    err_new = 1'b0;
    nf = m_flags;
    if (we) nf = (fi & mask) | (m_flags & ~mask);
    if (pu && po) begin
      err_new = 1'b1;
    end else if (pu) begin
      if (m_stack.size() == DEPTH) err_new = 1'b1;
      else m_stack.push_back(m_flags);
    end else if (po) begin
      if (m_stack.size() == 0) err_new = 1'b1;
      else nf = m_stack.pop_back();
    end
    if (err_new) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (cv) exp_q.push_back(model_cond(cc, nf));
    m_flags = nf;

    es.flags = m_flags;
    es.count = CW'(m_stack.size());
    es.full  = (m_stack.size() == DEPTH);
    es.empty = (m_stack.size() == 0);
    es.err   = m_err;
    es.tv    = cv;
    state_q.push_back(es);
  endtask

  task automatic idle();
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] fi);
    step(fi, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cond(input logic [3:0] cc);
    step(4'h0, 4'h0, 1'b0, 1'b1, cc, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    st_t es;
    logic [0:0] et;
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        es = state_q.pop_front();
        check("flags_out",   32'(flags_out),   32'(es.flags));
        check("stack_count", 32'(stack_count), 32'(es.count));
        check("stack_full",  32'(stack_full),  32'(es.full));
        check("stack_empty", 32'(stack_empty), 32'(es.empty));
        check("stack_err",   32'(stack_err),   32'(es.err));
        check("taken_valid", 32'(taken_valid), 32'(es.tv));
      end
      if (taken_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("taken_valid_unexpected", 32'(taken_valid), 32'(0));
        end else begin
          et = exp_q.pop_front();
          check("taken", 32'(taken), 32'(et));
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_flags_out"},   32'(flags_out),   32'(0));
    check({tag, "_taken"},       32'(taken),       32'(0));
    check({tag, "_taken_valid"}, 32'(taken_valid), 32'(0));
    check({tag, "_stack_count"}, 32'(stack_count), 32'(0));
    check({tag, "_stack_empty"}, 32'(stack_empty), 32'(1));
    check({tag, "_stack_full"},  32'(stack_full),  32'(0));
    check({tag, "_stack_err"},   32'(stack_err),   32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flags_in = '0; flags_we = 1'b0; flags_mask = '0;
    cond_valid = 1'b0; cond_code = '0;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    model_reset();
    #3;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Masked write
    step(4'hF, 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Forwarded condition
    wr(4'h0);
    step(4'h1, 4'hF, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    idle();

    // Signed compares, back-to-back requests
    wr(4'h2);
    cond(4'd10); cond(4'd11); cond(4'd13); cond(4'd12);
    wr(4'h4);
    cond(4'd8);

    // Stack LIFO fill, overflow, drain, underflow
    for (int i = 1; i <= 4; i++) begin
      wr(4'(i));
      step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    end
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Simultaneous events
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    wr(4'h9);
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    step(4'h6, 4'hF, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    // err_clr colliding with a new error: set wins
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Async reset mid-sequence with count=2, flags=A and a pending request
    wr(4'h3);
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    wr(4'hA);
    idle();
    @(negedge clk);
    cond_valid = 1'b1; cond_code = 4'd14;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    check_reset_values("async_reset_after_edge");
    @(negedge clk);
    cond_valid = 1'b0;
    rst = 1'b0;
    model_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic pu, po;
      r  = $urandom_range(0, 15);
      pu = (r < 4) || (r == 10);
      po = (r >= 4 && r < 8) || (r == 10);
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pu, po,
           ($urandom_range(0, 7) == 0));
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    check("state_q_drained", 32'(state_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
